// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared constants and helpers for the modulo up/down counter and its
// prescaler.
//   MODE_WRAP / MODE_SAT : encoding of the Mode input
//   DIR_DOWN  / DIR_UP   : encoding of the Up_Down input
//   clog2_min1()         : register width for a 0..value-1 counter, never 0
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // ceil(log2(value)), but at least 1 so a DIV=1 prescaler still has a
    // legal one-bit register.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/counter_mod_updown_if.sv
// -----------------------------------------------------------------------------
// counter_mod_updown_if
// Control/status bundle of the modulo up/down counter.
//   Data         load value (N bits)
//   Set_Enable   synchronous load request
//   Count_Enable allow stepping on a prescaler tick
//   Up_Down      1 = up, 0 = down
//   Mode         0 = wrap, 1 = saturate
//   Q            current count (N bits)
//   TC           one-cycle terminal-count pulse
//   Sat          sticky blocked-step flag
// master: the side driving controls (user logic / bench)
// slave : the counter itself
// -----------------------------------------------------------------------------
interface counter_mod_updown_if #(
    parameter int N = 4
);
    logic [N-1:0] Data;
    logic         Set_Enable;
    logic         Count_Enable;
    logic         Up_Down;
    logic         Mode;
    logic [N-1:0] Q;
    logic         TC;
    logic         Sat;

    modport master (
        output Data, Set_Enable, Count_Enable, Up_Down, Mode,
        input  Q, TC, Sat
    );

    modport slave (
        input  Data, Set_Enable, Count_Enable, Up_Down, Mode,
        output Q, TC, Sat
    );
endinterface

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running 0..DIV-1 cycle counter producing a one-clock step tick in the
// last cycle of each period.
//   CLK100MHZ in  board clock
//   reset     in  asynchronous active-low reset
//   restart   in  return to phase 0 on the next edge (used by counter loads)
//   tick      out high while the phase equals DIV-1 (constant 1 for DIV=1)
// -----------------------------------------------------------------------------
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int DIV = 100000
) (
    input  logic CLK100MHZ,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int         W    = clog2_min1(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // For DIV=1 LAST is 0, so cnt_q is pinned at 0 and tick never drops.
    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_mod_updown.sv
// -----------------------------------------------------------------------------
// counter_mod_updown
// Modulo-MODULUS up/down counter with synchronous clamped load, wrap or
// saturate at the range boundary, registered terminal-count pulse and a
// sticky saturation flag. Steps are paced by an internal prescaler so the
// block runs straight off the board clock.
//   CLK100MHZ in  board clock
//   reset     in  asynchronous active-low reset
//   bus       slave modport of counter_mod_updown_if (Data, Set_Enable,
//             Count_Enable, Up_Down, Mode in; Q, TC, Sat out)
// Priority each edge: load > (tick & Count_Enable) step > hold.
// -----------------------------------------------------------------------------
module counter_mod_updown
    import counter_pkg::*;
#(
    parameter int N       = 4,
    parameter int MODULUS = 16,
    parameter int DIV     = 100000
) (
    input  logic                 CLK100MHZ,
    input  logic                 reset,
    counter_mod_updown_if.slave  bus
);

    localparam logic [N-1:0] MAXV = N'(MODULUS - 1);

    logic         tick;
    logic [N-1:0] q_q, q_d;
    logic         tc_q, tc_d;
    logic         sat_q, sat_d;

    // A load restarts the prescaler so the first step lands DIV clocks later.
    tick_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .restart   (bus.Set_Enable),
        .tick      (tick)
    );

    always_comb begin
        q_d   = q_q;
        tc_d  = 1'b0;
        sat_d = sat_q;
        if (bus.Set_Enable) begin
            // Out-of-range load values are clamped to the top of the range.
            q_d   = (bus.Data > MAXV) ? MAXV : bus.Data;
            sat_d = 1'b0;
        end else if (tick && bus.Count_Enable) begin
            if (bus.Up_Down == DIR_UP) begin
                if (q_q == MAXV) begin
                    tc_d = 1'b1;
                    if (bus.Mode == MODE_WRAP) begin
                        q_d = '0;
                    end else begin
                        sat_d = 1'b1;
                    end
                end else begin
                    q_d = q_q + N'(1);
                end
            end else begin
                if (q_q == '0) begin
                    tc_d = 1'b1;
                    if (bus.Mode == MODE_WRAP) begin
                        q_d = MAXV;
                    end else begin
                        sat_d = 1'b1;
                    end
                end else begin
                    q_d = q_q - N'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            q_q   <= '0;
            tc_q  <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            sat_q <= sat_d;
        end
    end

    assign bus.Q   = q_q;
    assign bus.TC  = tc_q;
    assign bus.Sat = sat_q;

endmodule

// File: tb/tb_counter_mod_updown.sv
module tb_counter_mod_updown;

    logic clk;
    logic reset;

    int n_cmp;
    int n_err;

    counter_mod_updown_if #(.N(4)) if_a ();
    counter_mod_updown_if #(.N(4)) if_b ();

    counter_mod_updown #(.N(4), .MODULUS(10), .DIV(4)) dut_a (
        .CLK100MHZ (clk),
        .reset     (reset),
        .bus       (if_a)
    );

    counter_mod_updown #(.N(4), .MODULUS(16), .DIV(1)) dut_b (
        .CLK100MHZ (clk),
        .reset     (reset),
        .bus       (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: count, flags, and clocks elapsed since the last
    // reset or load (a tick falls on every DIV-th clock of that run).
    typedef struct {
        int q;
        int tc;
        int sat;
        int since;
    } mstate_t;

    mstate_t ma;
    mstate_t mb;

    function automatic mstate_t model_step(mstate_t s, bit rst_n, bit set, int data,
                                           bit ce, bit up, bit sat_mode,
                                           int modulus, int div);
        mstate_t r;
        bit      tick;
        r = s;
        if (!rst_n) begin
            r.q = 0; r.tc = 0; r.sat = 0; r.since = 0;
            return r;
        end
        tick    = ((s.since % div) == div - 1);
        r.tc    = 0;
        r.since = s.since + 1;
        if (set) begin
            r.q     = (data > modulus - 1) ? modulus - 1 : data;
            r.sat   = 0;
            r.since = 0;
        end else if (tick && ce) begin
            if (up) begin
                if (s.q == modulus - 1) begin
                    r.tc = 1;
                    if (sat_mode) r.sat = 1;
                    else          r.q   = 0;
                end else begin
                    r.q = s.q + 1;
                end
            end else begin
                if (s.q == 0) begin
                    r.tc = 1;
                    if (sat_mode) r.sat = 1;
                    else          r.q   = modulus - 1;
                end else begin
                    r.q = s.q - 1;
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_aQ"},   int'(if_a.Q),   ma.q);
        chk({tag, "_aTC"},  int'(if_a.TC),  ma.tc);
        chk({tag, "_aSat"}, int'(if_a.Sat), ma.sat);
        chk({tag, "_bQ"},   int'(if_b.Q),   mb.q);
        chk({tag, "_bTC"},  int'(if_b.TC),  mb.tc);
        chk({tag, "_bSat"}, int'(if_b.Sat), mb.sat);
    endtask

    // One clock: advance the models on the edge with the inputs applied,
    // then compare on the following falling edge.
    task automatic cycle();
        @(posedge clk);
        ma = model_step(ma, reset, if_a.Set_Enable, int'(if_a.Data), if_a.Count_Enable,
                        if_a.Up_Down, if_a.Mode, 10, 4);
        mb = model_step(mb, reset, if_b.Set_Enable, int'(if_b.Data), if_b.Count_Enable,
                        if_b.Up_Down, if_b.Mode, 16, 1);
        @(negedge clk);
        check_all("cyc");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};

        reset = 1'b0;
        if_a.Data = '0; if_a.Set_Enable = 1'b0; if_a.Count_Enable = 1'b1;
        if_a.Up_Down = 1'b1; if_a.Mode = 1'b0;
        if_b.Data = '0; if_b.Set_Enable = 1'b0; if_b.Count_Enable = 1'b0;
        if_b.Up_Down = 1'b1; if_b.Mode = 1'b0;

        // Reset held, then first steps.
        repeat (3) cycle();
        chk("t1_rstQ", int'(if_a.Q), 0);
        reset = 1'b1;
        repeat (4) cycle();
        chk("t1_q1", int'(if_a.Q), 1);
        repeat (4) cycle();
        chk("t1_q2", int'(if_a.Q), 2);

        // Up wrap.
        if_a.Set_Enable = 1'b1; if_a.Data = 4'd8; if_a.Mode = 1'b0; if_a.Up_Down = 1'b1;
        cycle();
        if_a.Set_Enable = 1'b0;
        chk("t2_q8", int'(if_a.Q), 8);
        repeat (4) cycle();
        chk("t2_q9", int'(if_a.Q), 9);
        repeat (3) cycle();
        chk("t2_tc_pre", int'(if_a.TC), 0);
        cycle();
        chk("t2_q0", int'(if_a.Q), 0);
        chk("t2_tc", int'(if_a.TC), 1);
        cycle();
        chk("t2_tc_post", int'(if_a.TC), 0);
        chk("t2_sat", int'(if_a.Sat), 0);

        // Down saturate.
        if_a.Set_Enable = 1'b1; if_a.Data = 4'd1; if_a.Mode = 1'b1; if_a.Up_Down = 1'b0;
        cycle();
        if_a.Set_Enable = 1'b0;
        chk("t3_q1", int'(if_a.Q), 1);
        repeat (4) cycle();
        chk("t3_q0", int'(if_a.Q), 0);
        chk("t3_tc0", int'(if_a.TC), 0);
        repeat (4) cycle();
        chk("t3_blk_q", int'(if_a.Q), 0);
        chk("t3_blk_tc", int'(if_a.TC), 1);
        chk("t3_sat", int'(if_a.Sat), 1);
        repeat (4) cycle();
        chk("t3_blk2_tc", int'(if_a.TC), 1);
        if_a.Set_Enable = 1'b1; if_a.Data = 4'd5;
        cycle();
        if_a.Set_Enable = 1'b0;
        chk("t3_q5", int'(if_a.Q), 5);
        chk("t3_satclr", int'(if_a.Sat), 0);

        // Clamped load on a tick cycle; next step four clocks later.
        for (int i = 0; i < 8 && (ma.since % 4) != 3; i++) cycle();
        chk("t4_ontick", ma.since % 4, 3);
        if_a.Set_Enable = 1'b1; if_a.Data = 4'd13; if_a.Up_Down = 1'b0; if_a.Mode = 1'b0;
        cycle();
        if_a.Set_Enable = 1'b0;
        chk("t4_clamp", int'(if_a.Q), 9);
        chk("t4_tc", int'(if_a.TC), 0);
        repeat (3) cycle();
        chk("t4_hold", int'(if_a.Q), 9);
        cycle();
        chk("t4_step", int'(if_a.Q), 8);

        // Enable gating across three tick periods.
        if_a.Count_Enable = 1'b0;
        repeat (12) cycle();
        chk("t5_gated", int'(if_a.Q), 8);
        if_a.Count_Enable = 1'b1;
        repeat (4) cycle();
        chk("t5_resume", int'(if_a.Q), 7);

        // DIV=1, MODULUS=16 instance: every-clock wrap, then async reset.
        if_a.Count_Enable = 1'b0;
        if_b.Set_Enable = 1'b1; if_b.Data = 4'd14; if_b.Up_Down = 1'b1;
        if_b.Mode = 1'b0; if_b.Count_Enable = 1'b1;
        cycle();
        if_b.Set_Enable = 1'b0;
        chk("t6_q14", int'(if_b.Q), 14);
        cycle();
        chk("t6_q15", int'(if_b.Q), 15);
        cycle();
        chk("t6_q0", int'(if_b.Q), 0);
        chk("t6_tc", int'(if_b.TC), 1);
        cycle();
        chk("t6_q1", int'(if_b.Q), 1);
        #2;
        reset = 1'b0;
        #1;
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        chk("t6_async_bQ", int'(if_b.Q), 0);
        chk("t6_async_aQ", int'(if_a.Q), 0);
        cycle();
        reset = 1'b1;

        // Randomized traffic on both instances.
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            if_a.Set_Enable   = ($urandom_range(0, 15) == 0);
            if_a.Data         = 4'($urandom_range(0, 15));
            if_a.Count_Enable = ($urandom_range(0, 3) != 0);
            if_a.Up_Down      = 1'($urandom);
            if_a.Mode         = 1'($urandom);
            if_b.Set_Enable   = ($urandom_range(0, 15) == 0);
            if_b.Data         = 4'($urandom_range(0, 15));
            if_b.Count_Enable = ($urandom_range(0, 3) != 0);
            if_b.Up_Down      = ($urandom_range(0, 7) != 0);
            if_b.Mode         = 1'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
